// File: rtl/add_iter_pkg.sv
// add_iter_pkg: shared FSM encoding, default widths and index-width helper for add_iter
//   ST_IDLE/ST_RUN/ST_DONE : 2-bit state encodings
//   DATAWIDTH_DEF, CHUNK_DEF: default operand width and bits summed per cycle
//   idx_w(n)                : counter width for n iterations, never below 1
package add_iter_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
   localparam int DATAWIDTH_DEF = 8;
   localparam int CHUNK_DEF = 2;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/add_iter_if.sv
// add_iter_if: start/busy/done request bundle with operands and result
//   start, a, b      : requester -> adder
//   busy, done, sum, cout : adder -> requester
//   master = requester side, slave = adder side
interface add_iter_if import add_iter_pkg::*; #(parameter int DATAWIDTH = DATAWIDTH_DEF);
   logic                 start;
   logic [DATAWIDTH-1:0] a;
   logic [DATAWIDTH-1:0] b;
   logic                 busy;
   logic                 done;
   logic [DATAWIDTH-1:0] sum;
   logic                 cout;
   modport master (output start, a, b, input busy, done, sum, cout);
   modport slave (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit adder slice with carry in/out
//   x, y : operand chunks
//   cin  : carry in
//   s    : chunk sum
//   co   : carry out of the chunk MSB
module chunk_adder import add_iter_pkg::*; #(parameter int CHUNK = CHUNK_DEF) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             co
);
   always_comb {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/add_iter.sv
// add_iter: multi-cycle adder, CHUNK bits per clock through a registered carry
//   Clk  : clock, rising edge
//   Rst  : synchronous active-high reset, aborts any operation in flight
//   bus  : slave side of add_iter_if (start/a/b in, busy/done/sum/cout out)
module add_iter import add_iter_pkg::*; #(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input logic      Clk,
   input logic      Rst,
   add_iter_if.slave bus
);
   localparam int N = DATAWIDTH / CHUNK;
   localparam int IW = idx_w(N);
   state_t               state, nxt;
   logic [DATAWIDTH-1:0] ra, rb, part, np;
   logic [IW-1:0]        idx;
   logic                 carry, co, accept, last;
   logic [CHUNK-1:0]     s;
   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .x(ra[idx*CHUNK +: CHUNK]),
      .y(rb[idx*CHUNK +: CHUNK]),
      .cin(carry),
      .s(s),
      .co(co)
   );
   always_comb begin
      accept = bus.start && (state == ST_IDLE || state == ST_DONE);
      last = (state == ST_RUN) && (idx == IW'(N - 1));
      nxt = accept ? ST_RUN : (state == ST_RUN) ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
      bus.busy = state == ST_RUN;
      bus.done = state == ST_DONE;
      // partial sum with the current chunk merged in; becomes sum on the last chunk
      np = part;
      np[idx*CHUNK +: CHUNK] = s;
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= ST_IDLE;
         ra <= '0;
         rb <= '0;
         part <= '0;
         idx <= '0;
         carry <= 1'b0;
         bus.sum <= '0;
         bus.cout <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            ra <= bus.a;
            rb <= bus.b;
            idx <= '0;
            carry <= 1'b0;
         end else if (state == ST_RUN) begin
            part <= np;
            carry <= co;
            idx <= idx + 1'b1;
            if (last) begin
               bus.sum <= np;
               bus.cout <= co;
            end
         end
      end
   end
endmodule

// File: tb/tb_add_iter.sv
// tb_add_iter: directed self-checking bench for add_iter (DATAWIDTH=8, CHUNK=2)
module tb_add_iter;
   logic clk, rst;
   int   checks, failures;
   logic [7:0] prev;
   add_iter_if #(.DATAWIDTH(8)) bus ();
   add_iter #(.DATAWIDTH(8), .CHUNK(2)) dut (.Clk(clk), .Rst(rst), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle_state(input string tag, input logic [7:0] s, input logic c);
      check({tag, ".busy"}, {31'b0, bus.busy}, 0);
      check({tag, ".done"}, {31'b0, bus.done}, 0);
      check({tag, ".sum"}, {24'b0, bus.sum}, {24'b0, s});
      check({tag, ".cout"}, {31'b0, bus.cout}, {31'b0, c});
   endtask
   // accepts at e0, expects busy for 4 samples with the old sum held, then done
   task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] es, input logic ec);
      bus.a = a;
      bus.b = b;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      bus.a = 8'h5A;
      bus.b = 8'hC3;
      for (int i = 0; i < 4; i++) begin
         check({tag, ".busy"}, {31'b0, bus.busy}, 1);
         check({tag, ".nodone"}, {31'b0, bus.done}, 0);
         check({tag, ".hold"}, {24'b0, bus.sum}, {24'b0, prev});
         tick;
      end
      check({tag, ".done"}, {31'b0, bus.done}, 1);
      check({tag, ".busy0"}, {31'b0, bus.busy}, 0);
      check({tag, ".sum"}, {24'b0, bus.sum}, {24'b0, es});
      check({tag, ".cout"}, {31'b0, bus.cout}, {31'b0, ec});
      check({tag, ".sub"}, {24'b0, bus.sum - b}, {24'b0, a});
      prev = es;
      tick;
      idle_state({tag, ".after"}, es, ec);
   endtask
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      checks = 0;
      failures = 0;
      prev = 8'h00;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.a = 8'h00;
      bus.b = 8'h00;
      tick;
      tick;
      idle_state("reset", 8'h00, 1'b0);
      rst = 1'b0;
      tick;
      tick;
      idle_state("quiet", 8'h00, 1'b0);
      op("basic", 8'h35, 8'h1A, 8'h4F, 1'b0);
      op("ff01", 8'hFF, 8'h01, 8'h00, 1'b1);
      op("8080", 8'h80, 8'h80, 8'h00, 1'b1);
      op("aa55", 8'hAA, 8'h55, 8'hFF, 1'b0);
      // start raised mid-RUN must be ignored
      bus.a = 8'h35;
      bus.b = 8'h1A;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      bus.start = 1'b1;
      bus.a = 8'h10;
      bus.b = 8'h10;
      tick;
      bus.start = 1'b0;
      tick;
      tick;
      check("busy_start.done", {31'b0, bus.done}, 1);
      check("busy_start.sum", {24'b0, bus.sum}, 8'h4F);
      for (int i = 0; i < 6; i++) begin
         tick;
         check("busy_start.single", {30'b0, bus.busy, bus.done}, 0);
      end
      // back-to-back with start held high
      bus.a = 8'h01;
      bus.b = 8'h02;
      bus.start = 1'b1;
      tick;
      bus.a = 8'h03;
      bus.b = 8'h04;
      for (int i = 0; i < 4; i++) tick;
      check("b2b.done1", {31'b0, bus.done}, 1);
      check("b2b.sum1", {24'b0, bus.sum}, 8'h03);
      for (int i = 0; i < 4; i++) begin
         tick;
         check("b2b.gap", {30'b0, bus.busy, bus.done}, 2);
         check("b2b.hold", {24'b0, bus.sum}, 8'h03);
      end
      bus.start = 1'b0;
      tick;
      check("b2b.done2", {31'b0, bus.done}, 1);
      check("b2b.sum2", {24'b0, bus.sum}, 8'h07);
      tick;
      check("b2b.end", {30'b0, bus.busy, bus.done}, 0);
      // reset during RUN abandons the operation
      bus.a = 8'hF0;
      bus.b = 8'h0F;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      idle_state("midrst", 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick;
         check("midrst.nodone", {30'b0, bus.busy, bus.done}, 0);
      end
      prev = 8'h00;
      op("postrst", 8'hF0, 8'h0F, 8'hFF, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
